// File: rtl/serial_a_paralelo_idle_pkg.sv
// Shared PHY symbol constants and FSM encodings for the serial IDLE link.
// Used by the transmitter and by serial_a_paralelo_idle.
package serial_a_paralelo_idle_pkg;

  localparam int         DATA_W_DEF  = 8;
  localparam logic [7:0] COM_SYM     = 8'hBC;
  localparam logic [7:0] IDLE_SYM    = 8'h7C;
  localparam int         ALIGN_DEF   = 4;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

endpackage

// File: rtl/serial_a_paralelo_idle.sv
// Serial-to-parallel IDLE receiver: COM hunt, byte lock, payload strobe.
// COM and IDLE filler are dropped once the link is active.
module serial_a_paralelo_idle
  import serial_a_paralelo_idle_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] COM         = COM_SYM,
  parameter logic [DATA_W-1:0] IDLE        = IDLE_SYM,
  parameter int                ALIGN_COUNT = ALIGN_DEF
) (
  input  logic              clk32f,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);

  localparam int BW  = $clog2(DATA_W);
  localparam int CW  = $clog2(ALIGN_COUNT) + 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] NEED = CW'(ALIGN_COUNT);

  logic [1:0]        state;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] nxt;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     bc_cnt;
  logic [CW-1:0]     bc_inc;
  logic              boundary;
  logic              is_com;
  logic              is_idle;

  assign nxt      = {sr[DATA_W-2:0], in};
  assign bc_inc   = bc_cnt + CW'(1);
  assign boundary = (bit_cnt == LAST);
  assign is_com   = (nxt == COM);
  assign is_idle  = (nxt == IDLE);

  always_ff @(posedge clk32f) begin
    if (!reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= nxt;
      valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          if (is_com) begin
            state   <= ALIGN;
            bc_cnt  <= CW'(1);
            bit_cnt <= '0;
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + BW'(1);
          if (boundary) begin
            if (is_com && bc_inc == NEED) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else if (is_com) begin
              bc_cnt <= bc_inc;
            end else begin
              // a broken COM run forces a fresh bit-level hunt
              state  <= SEARCH;
              bc_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + BW'(1);
          if (boundary && !is_com && !is_idle) begin
            data_out  <= nxt;
            valid_out <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_a_paralelo_idle.sv
// Directed bench for serial_a_paralelo_idle.
// Scenario tasks check every edge against hand-derived timing.
module tb_serial_a_paralelo_idle;

  logic       clk32f = 1'b0;
  logic       reset  = 1'b0;
  logic       in_bit = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk32f = ~clk32f;

  serial_a_paralelo_idle dut (
    .clk32f   (clk32f),
    .reset    (reset),
    .in       (in_bit),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  task automatic shift_bit(input logic b);
    @(negedge clk32f);
    in_bit = b;
    @(posedge clk32f);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk32f);
    reset  = 1'b0;
    in_bit = 1'b0;
    @(posedge clk32f);
    #1;
    @(negedge clk32f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk32f);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk32f);
      in_bit = 1'($urandom_range(1));
      @(posedge clk32f);
      #1;
      n_cmp++;
      if ({data_out, valid_out, active} !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_hold: got %h/%b/%b want 00/0/0",
                 data_out, valid_out, active);
      end
    end
    @(negedge clk32f);
    reset = 1'b1;
    shift_bit(1'b1);
    n_cmp++;
    if ({data_out, valid_out, active} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_release: got %h/%b/%b want 00/0/0",
               data_out, valid_out, active);
    end
  endtask

  task automatic test_lock_payload();
    logic [7:0] s [0:6];
    int e;
    logic [7:0] ed;
    s = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'h7C, 8'h3C};
    do_reset();
    e = 0;
    for (int k = 0; k < 7; k++) begin
      for (int b = 7; b >= 0; b--) begin
        e++;
        shift_bit(s[k][b]);
        ed = (e >= 56) ? 8'h3C : (e >= 40) ? 8'hA5 : 8'h00;
        n_cmp++;
        if (active !== (e >= 32) || valid_out !== (e == 40 || e == 56)
            || data_out !== ed) begin
          n_bad++;
          $display("FAIL lock_payload e%0d: got %b/%b/%h want %b/%b/%h",
                   e, active, valid_out, data_out,
                   e >= 32, e == 40 || e == 56, ed);
        end
      end
    end
  endtask

  task automatic test_offset();
    logic [7:0] s [0:4];
    logic       pre [0:2];
    int e;
    s   = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h5A};
    pre = '{1'b1, 1'b0, 1'b1};
    do_reset();
    e = 0;
    for (int i = 0; i < 3; i++) begin
      e++;
      shift_bit(pre[i]);
    end
    for (int k = 0; k < 5; k++) begin
      for (int b = 7; b >= 0; b--) begin
        e++;
        shift_bit(s[k][b]);
        n_cmp++;
        if (active !== (e >= 35) || valid_out !== (e == 43)
            || data_out !== ((e >= 43) ? 8'h5A : 8'h00)) begin
          n_bad++;
          $display("FAIL offset e%0d: got %b/%b/%h want %b/%b/%h",
                   e, active, valid_out, data_out,
                   e >= 35, e == 43, (e >= 43) ? 8'h5A : 8'h00);
        end
      end
    end
  endtask

  task automatic test_broken_run();
    logic [7:0] s [0:7];
    int e;
    s = '{8'hBC, 8'hBC, 8'hBC, 8'h7C, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    e = 0;
    for (int k = 0; k < 8; k++) begin
      for (int b = 7; b >= 0; b--) begin
        e++;
        shift_bit(s[k][b]);
        n_cmp++;
        if (active !== (e >= 64) || valid_out !== 1'b0
            || data_out !== 8'h00) begin
          n_bad++;
          $display("FAIL broken_run e%0d: got %b/%b/%h want %b/0/00",
                   e, active, valid_out, data_out, e >= 64);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [0:6];
    int e;
    logic [7:0] ed;
    s = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h01, 8'h80, 8'hFF};
    do_reset();
    e = 0;
    for (int k = 0; k < 7; k++) begin
      for (int b = 7; b >= 0; b--) begin
        e++;
        shift_bit(s[k][b]);
        ed = (e >= 56) ? 8'hFF : (e >= 48) ? 8'h80 :
             (e >= 40) ? 8'h01 : 8'h00;
        n_cmp++;
        if (valid_out !== (e == 40 || e == 48 || e == 56)
            || data_out !== ed || active !== (e >= 32)) begin
          n_bad++;
          $display("FAIL back_to_back e%0d: got %b/%b/%h want %b/%b/%h",
                   e, active, valid_out, data_out, e >= 32,
                   e == 40 || e == 48 || e == 56, ed);
        end
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] s [0:4];
    int e;
    s = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11};
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int b = 7; b >= 0; b--)
        shift_bit(s[k][b]);
    for (int i = 0; i < 4; i++)
      shift_bit(1'b1);
    n_cmp++;
    if (active !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_byte_locked: got active=%b want 1", active);
    end
    @(negedge clk32f);
    reset  = 1'b0;
    in_bit = 1'b0;
    @(posedge clk32f);
    #1;
    n_cmp++;
    if ({data_out, valid_out, active} !== 10'd0) begin
      n_bad++;
      $display("FAIL mid_byte_reset: got %h/%b/%b want 00/0/0",
               data_out, valid_out, active);
    end
    @(negedge clk32f);
    reset = 1'b1;
    e = 0;
    for (int k = 0; k < 5; k++) begin
      for (int b = 7; b >= 0; b--) begin
        e++;
        shift_bit(s[k][b]);
        n_cmp++;
        if (active !== (e >= 32) || valid_out !== (e == 40)
            || data_out !== ((e >= 40) ? 8'h11 : 8'h00)) begin
          n_bad++;
          $display("FAIL relock e%0d: got %b/%b/%h want %b/%b/%h",
                   e, active, valid_out, data_out,
                   e >= 32, e == 40, (e >= 40) ? 8'h11 : 8'h00);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_payload();
    test_offset();
    test_broken_run();
    test_back_to_back();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
